vm_payout_ctrl: RTL and testbench

//  Control sequencer for the two-coin vending machine: accumulates credit from coin inputs a/b,

---
 rtl/vm_payout_ctrl_pkg.sv | 28 ++
 rtl/vm_payout_ctrl_if.sv | 11 +
 rtl/vm_payout_ctrl_seq.sv | 55 +++++
 rtl/vm_payout_ctrl.sv | 151 +++++++++++++++
 tb/tb_vm_payout_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_payout_ctrl_pkg.sv
// Shared types and default constants for the two-coin vending payout controller.
// Coin values and prices are in coin-a units.
package vm_payout_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      PAYOUT = 2'd2
   } state_t;

   typedef enum logic {
      COIN_A = 1'b0,
      COIN_B = 1'b1
   } coin_t;

   localparam int DEF_CREDIT_W   = 4;
   localparam int DEF_VAL_A      = 1;
   localparam int DEF_VAL_B      = 5;
   localparam int DEF_PRICE0     = 3;
   localparam int DEF_PRICE1     = 8;
   localparam int DEF_MAX_CREDIT = 15;

   // Greedy change: hand out the large coin whenever the remaining credit covers it.
   function automatic coin_t pick_coin(input int unsigned credit, input int unsigned val_b);
      return (credit >= val_b) ? COIN_B : COIN_A;
   endfunction

endpackage

// File: rtl/vm_payout_ctrl_if.sv
// Coin dispenser valid/ready link; the controller is master, the dispenser is slave.
interface vm_payout_ctrl_if;

   logic disp_vld;
   logic disp_coin;
   logic disp_rdy;

   modport master (output disp_vld, output disp_coin, input disp_rdy);
   modport slave  (input disp_vld, input disp_coin, output disp_rdy);

endinterface

// File: rtl/vm_payout_ctrl_seq.sv
// Payout sequencer: holds the offered coin on the dispenser link and tells the
// parent how much credit each accepted coin removes.
module vm_payout_ctrl_seq
   import vm_payout_ctrl_pkg::*;
#(
   parameter int CREDIT_W = DEF_CREDIT_W,
   parameter int VAL_A    = DEF_VAL_A,
   parameter int VAL_B    = DEF_VAL_B
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [CREDIT_W-1:0] i_credit,
   vm_payout_ctrl_if.master    disp,
   output logic                o_xfer,
   output logic                o_last,
   output logic [CREDIT_W-1:0] o_credit_nxt
);

   logic                r_vld;
   coin_t               r_coin;
   logic [CREDIT_W-1:0] w_dec;
   logic [CREDIT_W-1:0] w_rem;
   logic                w_xfer;

   assign w_xfer = r_vld & disp.disp_rdy;
   assign w_dec  = (r_coin == COIN_B) ? CREDIT_W'(VAL_B) : CREDIT_W'(VAL_A);
   assign w_rem  = i_credit - w_dec;

   assign o_xfer       = w_xfer;
   assign o_last       = (w_rem == '0);
   assign o_credit_nxt = w_rem;

   assign disp.disp_vld  = r_vld;
   assign disp.disp_coin = r_coin;

   // The coin choice only moves on start or after an accepted transfer, so it
   // stays stable while the dispenser stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_coin <= COIN_A;
      end else if (i_start) begin
         r_vld  <= 1'b1;
         r_coin <= pick_coin(32'(i_credit), VAL_B);
      end else if (w_xfer) begin
         if (w_rem == '0) begin
            r_vld <= 1'b0;
         end else begin
            r_coin <= pick_coin(32'(w_rem), VAL_B);
         end
      end
   end

endmodule

// File: rtl/vm_payout_ctrl.sv
// Vending control sequencer: credit accumulation, select arbitration, vend strobe,
// and hand-off to the payout sequencer for change.
module vm_payout_ctrl
   import vm_payout_ctrl_pkg::*;
#(
   parameter int CREDIT_W   = DEF_CREDIT_W,
   parameter int VAL_A      = DEF_VAL_A,
   parameter int VAL_B      = DEF_VAL_B,
   parameter int PRICE0     = DEF_PRICE0,
   parameter int PRICE1     = DEF_PRICE1,
   parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_a,
   input  logic                i_b,
   input  logic                i_sel_vld,
   input  logic                i_sel_id,
   input  logic                i_cancel,
   vm_payout_ctrl_if.master    disp,
   output logic                o_vend,
   output logic                o_vend_id,
   output logic                o_coin_rej,
   output logic                o_no_funds,
   output logic [CREDIT_W-1:0] o_credit,
   output logic                o_busy
);

   state_t              r_state,     w_state_nxt;
   logic [CREDIT_W-1:0] r_credit,    w_credit_nxt;
   logic                r_vend,      w_vend_nxt;
   logic                r_vend_id,   w_vend_id_nxt;
   logic                r_coin_rej,  w_coin_rej_nxt;
   logic                r_no_funds,  w_no_funds_nxt;
   logic                r_busy;

   logic                w_start;
   logic                w_xfer;
   logic                w_last;
   logic [CREDIT_W-1:0] w_pay_credit;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W-1:0] w_price;

   // One extra bit so a near-full credit plus a coin cannot wrap into an accept.
   assign w_sum   = {1'b0, r_credit} + (CREDIT_W+1)'(i_b ? VAL_B : VAL_A);
   assign w_price = i_sel_id ? CREDIT_W'(PRICE1) : CREDIT_W'(PRICE0);

   vm_payout_ctrl_seq #(
      .CREDIT_W (CREDIT_W),
      .VAL_A    (VAL_A),
      .VAL_B    (VAL_B)
   ) u_seq (
      .clk          (clk),
      .rst          (rst),
      .i_start      (w_start),
      .i_credit     (r_credit),
      .disp         (disp),
      .o_xfer       (w_xfer),
      .o_last       (w_last),
      .o_credit_nxt (w_pay_credit)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_credit_nxt   = r_credit;
      w_vend_nxt     = 1'b0;
      w_vend_id_nxt  = r_vend_id;
      w_coin_rej_nxt = 1'b0;
      w_no_funds_nxt = 1'b0;
      w_start        = 1'b0;
      unique case (r_state)
         IDLE: begin
            // One event per cycle: cancel beats select beats coins.
            if (i_cancel) begin
               w_coin_rej_nxt = i_a | i_b;
               if (r_credit != '0) begin
                  w_state_nxt = PAYOUT;
                  w_start     = 1'b1;
               end
            end else if (i_sel_vld) begin
               w_coin_rej_nxt = i_a | i_b;
               if (r_credit >= w_price) begin
                  w_credit_nxt  = r_credit - w_price;
                  w_vend_nxt    = 1'b1;
                  w_vend_id_nxt = i_sel_id;
                  w_state_nxt   = VEND;
               end else begin
                  w_no_funds_nxt = 1'b1;
               end
            end else if (i_a & i_b) begin
               w_coin_rej_nxt = 1'b1;
            end else if (i_a | i_b) begin
               if (w_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                  w_credit_nxt = w_sum[CREDIT_W-1:0];
               end else begin
                  w_coin_rej_nxt = 1'b1;
               end
            end
         end
         VEND: begin
            w_coin_rej_nxt = i_a | i_b;
            if (r_credit != '0) begin
               w_state_nxt = PAYOUT;
               w_start     = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PAYOUT: begin
            w_coin_rej_nxt = i_a | i_b;
            if (w_xfer) begin
               w_credit_nxt = w_pay_credit;
               if (w_last) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_credit   <= '0;
         r_vend     <= 1'b0;
         r_vend_id  <= 1'b0;
         r_coin_rej <= 1'b0;
         r_no_funds <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_vend     <= w_vend_nxt;
         r_vend_id  <= w_vend_id_nxt;
         r_coin_rej <= w_coin_rej_nxt;
         r_no_funds <= w_no_funds_nxt;
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   assign o_vend     = r_vend;
   assign o_vend_id  = r_vend_id;
   assign o_coin_rej = r_coin_rej;
   assign o_no_funds = r_no_funds;
   assign o_credit   = r_credit;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_vm_payout_ctrl.sv
// Bench for vm_payout_ctrl: directed scenarios plus random traffic against a
// transaction-style reference model (credit arithmetic and a greedy change queue).
module tb_vm_payout_ctrl;

   localparam int PRICE0 = 3;
   localparam int PRICE1 = 8;
   localparam int VAL_A  = 1;
   localparam int VAL_B  = 5;
   localparam int MAXC   = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       a, b, sel_vld, sel_id, cancel;
   logic       vend, vend_id, coin_rej, no_funds, busy;
   logic [3:0] credit;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_mode;
   int m_credit;
   bit m_vend, m_id, m_rej, m_nf, m_busy;
   bit m_q[$];

   always #5 clk = ~clk;

   vm_payout_ctrl_if dif ();

   vm_payout_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .i_a        (a),
      .i_b        (b),
      .i_sel_vld  (sel_vld),
      .i_sel_id   (sel_id),
      .i_cancel   (cancel),
      .disp       (dif.master),
      .o_vend     (vend),
      .o_vend_id  (vend_id),
      .o_coin_rej (coin_rej),
      .o_no_funds (no_funds),
      .o_credit   (credit),
      .o_busy     (busy)
   );

   function automatic void start_payout();
      int c;
      c = m_credit;
      m_q.delete();
      while (c >= VAL_B) begin m_q.push_back(1'b1); c -= VAL_B; end
      while (c > 0)      begin m_q.push_back(1'b0); c -= VAL_A; end
      m_mode = 2;
   endfunction

   function automatic void model_step();
      int price, v;
      if (rst) begin
         m_mode = 0; m_credit = 0; m_vend = 0; m_id = 0; m_rej = 0; m_nf = 0;
         m_q.delete();
      end else begin
         m_vend = 0; m_rej = 0; m_nf = 0;
         case (m_mode)
            0: begin
               if (cancel) begin
                  m_rej = a | b;
                  if (m_credit > 0) start_payout();
               end else if (sel_vld) begin
                  m_rej = a | b;
                  price = sel_id ? PRICE1 : PRICE0;
                  if (m_credit >= price) begin
                     m_credit -= price; m_vend = 1; m_id = sel_id; m_mode = 1;
                  end else m_nf = 1;
               end else if (a && b) begin
                  m_rej = 1;
               end else if (a || b) begin
                  v = a ? VAL_A : VAL_B;
                  if (m_credit + v <= MAXC) m_credit += v;
                  else m_rej = 1;
               end
            end
            1: begin
               m_rej = a | b;
               if (m_credit > 0) start_payout();
               else m_mode = 0;
            end
            default: begin
               m_rej = a | b;
               if (dif.disp_rdy && m_q.size() > 0) begin
                  m_credit -= m_q[0] ? VAL_B : VAL_A;
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_mode = 0;
               end
            end
         endcase
      end
      m_busy = (m_mode != 0);
   endfunction

   task automatic cycle(input bit ia, input bit ib, input bit is, input bit iid,
                        input bit ic, input bit ir, input bit irst = 1'b0);
      a = ia; b = ib; sel_vld = is; sel_id = iid; cancel = ic;
      dif.disp_rdy = ir; rst = irst;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({credit, dif.disp_vld, busy, vend, vend_id, coin_rej, no_funds} !== 10'd0) begin
         errors++;
         $display("FAIL reset_state: got credit=%0d vld=%b busy=%b vend=%b id=%b rej=%b nf=%b want all 0",
                  credit, dif.disp_vld, busy, vend, vend_id, coin_rej, no_funds);
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_accum_vend();
      for (int i = 1; i <= 4; i++) begin
         cycle(1, 0, 0, 0, 0, 1);
         checks++;
         if (credit !== 4'(i)) begin
            errors++; $display("FAIL accum_a: got credit=%0d want %0d", credit, i);
         end
      end
      cycle(0, 0, 1, 0, 0, 1);
      checks++;
      if ({vend, vend_id, credit, busy, dif.disp_vld} !== {1'b1, 1'b0, 4'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sel0_vend: got vend=%b id=%b credit=%0d busy=%b vld=%b want 1 0 1 1 0",
                  vend, vend_id, credit, busy, dif.disp_vld);
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({vend, dif.disp_vld, dif.disp_coin, credit} !== {1'b0, 1'b1, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL sel0_offer: got vend=%b vld=%b coin=%b credit=%0d want 0 1 0 1",
                  vend, dif.disp_vld, dif.disp_coin, credit);
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({dif.disp_vld, busy, credit} !== {1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL sel0_done: got vld=%b busy=%b credit=%0d want 0 0 0", dif.disp_vld, busy, credit);
      end
   endtask

   task automatic test_overflow_change();
      bit exp_coin[3] = '{1'b1, 1'b0, 1'b0};
      int exp_cr[3]   = '{7, 2, 1};
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 1);
      checks++;
      if (credit !== 4'd15) begin
         errors++; $display("FAIL fill_b: got credit=%0d want 15", credit);
      end
      cycle(1, 0, 0, 0, 0, 1);
      checks++;
      if ({coin_rej, credit} !== {1'b1, 4'd15}) begin
         errors++; $display("FAIL overflow_rej: got rej=%b credit=%0d want 1 15", coin_rej, credit);
      end
      cycle(0, 0, 1, 1, 0, 1);
      checks++;
      if ({vend, vend_id, credit} !== {1'b1, 1'b1, 4'd7}) begin
         errors++; $display("FAIL sel1_vend: got vend=%b id=%b credit=%0d want 1 1 7", vend, vend_id, credit);
      end
      cycle(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({dif.disp_vld, dif.disp_coin, credit} !== {1'b1, exp_coin[k], 4'(exp_cr[k])}) begin
            errors++;
            $display("FAIL change_seq%0d: got vld=%b coin=%b credit=%0d want 1 %b %0d",
                     k, dif.disp_vld, dif.disp_coin, credit, exp_coin[k], exp_cr[k]);
         end
         cycle(0, 0, 0, 0, 0, 1);
      end
      checks++;
      if ({dif.disp_vld, busy, credit} !== {1'b0, 1'b0, 4'd0}) begin
         errors++; $display("FAIL change_done: got vld=%b busy=%b credit=%0d want 0 0 0", dif.disp_vld, busy, credit);
      end
   endtask

   task automatic test_no_funds_cancel();
      cycle(1, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 1);
      cycle(0, 0, 1, 1, 0, 1);
      checks++;
      if ({no_funds, vend, busy, credit} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
         errors++; $display("FAIL no_funds: got nf=%b vend=%b busy=%b credit=%0d want 1 0 0 2", no_funds, vend, busy, credit);
      end
      cycle(0, 0, 0, 0, 1, 1);
      checks++;
      if ({no_funds, dif.disp_vld, dif.disp_coin, credit} !== {1'b0, 1'b1, 1'b0, 4'd2}) begin
         errors++; $display("FAIL cancel_offer: got nf=%b vld=%b coin=%b credit=%0d want 0 1 0 2",
                            no_funds, dif.disp_vld, dif.disp_coin, credit);
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({dif.disp_vld, dif.disp_coin, credit} !== {1'b1, 1'b0, 4'd1}) begin
         errors++; $display("FAIL cancel_second: got vld=%b coin=%b credit=%0d want 1 0 1", dif.disp_vld, dif.disp_coin, credit);
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({dif.disp_vld, busy, credit} !== {1'b0, 1'b0, 4'd0}) begin
         errors++; $display("FAIL cancel_done: got vld=%b busy=%b credit=%0d want 0 0 0", dif.disp_vld, busy, credit);
      end
   endtask

   task automatic test_stall();
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         checks++;
         if ({dif.disp_vld, dif.disp_coin, credit} !== {1'b1, 1'b1, 4'd6}) begin
            errors++; $display("FAIL stall%0d: got vld=%b coin=%b credit=%0d want 1 1 6", i, dif.disp_vld, dif.disp_coin, credit);
         end
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({dif.disp_vld, dif.disp_coin, credit} !== {1'b1, 1'b0, 4'd1}) begin
         errors++; $display("FAIL stall_release: got vld=%b coin=%b credit=%0d want 1 0 1", dif.disp_vld, dif.disp_coin, credit);
      end
      cycle(0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reject();
      cycle(1, 1, 0, 0, 0, 1);
      checks++;
      if ({coin_rej, credit} !== {1'b1, 4'd0}) begin
         errors++; $display("FAIL ab_same_cycle: got rej=%b credit=%0d want 1 0", coin_rej, credit);
      end
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0, 0);
      checks++;
      if ({coin_rej, credit, dif.disp_vld} !== {1'b1, 4'd2, 1'b1}) begin
         errors++; $display("FAIL coin_in_payout: got rej=%b credit=%0d vld=%b want 1 2 1", coin_rej, credit, dif.disp_vld);
      end
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset_mid_payout();
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({credit, dif.disp_vld, busy} !== {4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rst_mid_payout: got credit=%0d vld=%b busy=%b want 0 0 0", credit, dif.disp_vld, busy);
      end
      cycle(0, 0, 0, 0, 0, 1);
      checks++;
      if ({credit, dif.disp_vld, busy} !== {4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rst_no_resume: got credit=%0d vld=%b busy=%b want 0 0 0", credit, dif.disp_vld, busy);
      end
   endtask

   task automatic test_random();
      logic [9:0] got, exp;
      int n;
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
               1'($urandom_range(0, 1)), $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60,
               $urandom_range(0, 199) == 0);
         got = {vend, vend_id, coin_rej, no_funds, busy, dif.disp_vld, credit};
         exp = {m_vend, m_id, m_rej, m_nf, m_busy, m_q.size() > 0, 4'(m_credit)};
         checks++;
         if (got !== exp || (dif.disp_vld === 1'b1 && dif.disp_coin !== m_q[0])) begin
            errors++;
            $display("FAIL random_cyc%0d: got vend/id/rej/nf/busy/vld/credit=%b coin=%b want %b coin=%b",
                     i, got, dif.disp_coin, exp, (m_q.size() > 0) ? m_q[0] : 1'b0);
         end
      end
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         cycle(0, 0, 0, 0, 0, 1);
         n++;
      end
      checks++;
      if (busy !== 1'b0 || dif.disp_vld !== 1'b0) begin
         errors++; $display("FAIL drain_timeout: got busy=%b vld=%b after %0d cycles want 0 0", busy, dif.disp_vld, n);
      end
   endtask

   initial begin
      a = 0; b = 0; sel_vld = 0; sel_id = 0; cancel = 0; dif.disp_rdy = 0; rst = 1;
      test_reset();
      test_accum_vend();
      test_overflow_change();
      test_no_funds_cancel();
      test_stall();
      test_reject();
      test_reset_mid_payout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
